freq_scan_ctrl: RTL and testbench



---
 rtl/freq_scan_pkg.sv | 17 +
 rtl/freq_gate_counter.sv | 56 +++++
 rtl/freq_scan_ctrl.sv | 175 +++++++++++++++++
 tb/tb_freq_scan_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_scan_pkg.sv
// Shared types and constants for the round-robin frequency scan controller.
package freq_scan_pkg;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned FREQ_W   = 20;
    localparam int unsigned CNT_W    = 21;
    localparam logic [FREQ_W-1:0] FREQ_MAX = 20'hFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        NEXT,
        SELECT,
        GATE,
        STORE
    } state_t;

endpackage

// File: rtl/freq_gate_counter.sv
// Edge detector, gate timer and saturating edge counter shared by all scan channels.
module freq_gate_counter
    import freq_scan_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 20_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             run,
    input  logic             sig,
    output logic             done,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned TW = $clog2(GATE_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_CYCLES - 1);

    logic             sig_d_q, sig_d_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rise;

    always_comb begin
        sig_d_d = sig;
        rise    = sig & ~sig_d_q;
        timer_d = timer_q;
        count_d = count_q;
        if (clear) begin
            timer_d = '0;
            count_d = '0;
        end else if (run) begin
            timer_d = timer_q + 1'b1;
            if (rise && (count_q != {CNT_W{1'b1}})) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_d_q <= 1'b0;
            timer_q <= '0;
            count_q <= '0;
        end else begin
            sig_d_q <= sig_d_d;
            timer_q <= timer_d;
            count_q <= count_d;
        end
    end

    // Last gate cycle: the final edge of the window still lands in count_q for STORE.
    assign done  = run && (timer_q == TIMER_LAST);
    assign count = count_q;

endmodule

// File: rtl/freq_scan_ctrl.sv
// Round-robin frequency measurement across four pulse inputs with one shared gate counter.
module freq_scan_ctrl
    import freq_scan_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 20_000_000,
    parameter int unsigned GATE_CYCLES   = 20_000_000,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scan_en,
    input  logic [3:0]    chan_en,
    input  logic          pulse_sig_1,
    input  logic          pulse_sig_2,
    input  logic          pulse_sig_3,
    input  logic          pulse_sig_4,
    output logic [19:0]   freq_out_1,
    output logic [19:0]   freq_out_2,
    output logic [19:0]   freq_out_3,
    output logic [19:0]   freq_out_4,
    output logic [3:0]    freq_vld,
    output logic [3:0]    freq_ovf,
    output logic          busy,
    output logic [1:0]    cur_chan
);

    localparam int unsigned SCALE = CLK_FREQ / GATE_CYCLES;
    localparam int unsigned SW    = $clog2(SETTLE_CYCLES);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam int unsigned PW    = CNT_W + 32;

    logic [NUM_CH-1:0] sync1_q, sync2_q;
    state_t            state_q, state_d;
    logic [1:0]        cur_chan_q, cur_chan_d;
    logic [1:0]        last_chan_q, last_chan_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [FREQ_W-1:0] freq_q [NUM_CH];
    logic [FREQ_W-1:0] freq_d [NUM_CH];
    logic [NUM_CH-1:0] vld_q, vld_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic              busy_q, busy_d;

    logic              sel;
    logic              clear;
    logic              run;
    logic              gate_done;
    logic [CNT_W-1:0]  count;
    logic [PW-1:0]     product;
    logic              sat;
    logic [1:0]        next_chan;
    logic [1:0]        idx;
    logic              found;

    assign sel = sync2_q[cur_chan_q];

    freq_gate_counter #(
        .GATE_CYCLES (GATE_CYCLES)
    ) u_gate (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .run   (run),
        .sig   (sel),
        .done  (gate_done),
        .count (count)
    );

    assign product = PW'(count) * PW'(SCALE);
    assign sat     = product > PW'(FREQ_MAX);

    // Search starts one past last_chan so a lone enabled channel wraps back onto itself.
    always_comb begin
        next_chan = last_chan_q;
        found     = 1'b0;
        idx       = '0;
        for (int i = 1; i <= int'(NUM_CH); i++) begin
            idx = last_chan_q + 2'(i);
            if (!found && chan_en[idx]) begin
                next_chan = idx;
                found     = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_chan_d  = cur_chan_q;
        last_chan_d = last_chan_q;
        settle_d    = settle_q;
        freq_d      = freq_q;
        ovf_d       = ovf_q;
        vld_d       = '0;
        clear       = 1'b0;
        run         = 1'b0;
        case (state_q)
            IDLE: begin
                if (scan_en && |chan_en) state_d = NEXT;
            end
            NEXT: begin
                if (!scan_en || !found) begin
                    state_d = IDLE;
                end else begin
                    cur_chan_d = next_chan;
                    settle_d   = '0;
                    state_d    = SELECT;
                end
            end
            SELECT: begin
                clear = 1'b1;
                if (!chan_en[cur_chan_q]) begin
                    state_d     = NEXT;
                    last_chan_d = cur_chan_q;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = GATE;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            GATE: begin
                run = 1'b1;
                if (!chan_en[cur_chan_q]) begin
                    state_d     = NEXT;
                    last_chan_d = cur_chan_q;
                end else if (gate_done) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                freq_d[cur_chan_q] = sat ? FREQ_MAX : product[FREQ_W-1:0];
                ovf_d[cur_chan_q]  = sat;
                vld_d[cur_chan_q]  = 1'b1;
                last_chan_d        = cur_chan_q;
                state_d            = NEXT;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            state_q     <= IDLE;
            cur_chan_q  <= 2'd0;
            last_chan_q <= 2'd3;
            settle_q    <= '0;
            for (int i = 0; i < int'(NUM_CH); i++) freq_q[i] <= '0;
            vld_q       <= '0;
            ovf_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            sync1_q     <= {pulse_sig_4, pulse_sig_3, pulse_sig_2, pulse_sig_1};
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cur_chan_q  <= cur_chan_d;
            last_chan_q <= last_chan_d;
            settle_q    <= settle_d;
            freq_q      <= freq_d;
            vld_q       <= vld_d;
            ovf_q       <= ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign freq_out_1 = freq_q[0];
    assign freq_out_2 = freq_q[1];
    assign freq_out_3 = freq_q[2];
    assign freq_out_4 = freq_q[3];
    assign freq_vld   = vld_q;
    assign freq_ovf   = ovf_q;
    assign busy       = busy_q;
    assign cur_chan   = cur_chan_q;

endmodule

// File: tb/tb_freq_scan_ctrl.sv
// Directed self-checking bench for freq_scan_ctrl with a 2000-cycle gate (scale 10000).
module tb_freq_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_en;
    logic [3:0]  chan_en;
    logic [3:0]  plse;
    logic [19:0] fo1, fo2, fo3, fo4;
    logic [3:0]  freq_vld, freq_ovf;
    logic        busy;
    logic [1:0]  cur_chan;

    int per [4];
    int pcnt [4];
    int exp_hz [4];
    int n_pass = 0;
    int n_total = 0;

    freq_scan_ctrl #(
        .CLK_FREQ      (20_000_000),
        .GATE_CYCLES   (2000),
        .SETTLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_en     (scan_en),
        .chan_en     (chan_en),
        .pulse_sig_1 (plse[0]),
        .pulse_sig_2 (plse[1]),
        .pulse_sig_3 (plse[2]),
        .pulse_sig_4 (plse[3]),
        .freq_out_1  (fo1),
        .freq_out_2  (fo2),
        .freq_out_3  (fo3),
        .freq_out_4  (fo4),
        .freq_vld    (freq_vld),
        .freq_ovf    (freq_ovf),
        .busy        (busy),
        .cur_chan    (cur_chan)
    );

    initial forever #5 clk = ~clk;

    // Square waves, high for the first half of each period.
    initial begin
        plse = '0;
        for (int c = 0; c < 4; c++) pcnt[c] = 0;
        forever begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (pcnt[c] + 1 >= per[c]) pcnt[c] = 0;
                else pcnt[c] = pcnt[c] + 1;
                plse[c] = (pcnt[c] < per[c] / 2);
            end
        end
    end

    function automatic logic [19:0] fout(input int c);
        case (c)
            0: return fo1;
            1: return fo2;
            2: return fo3;
            default: return fo4;
        endcase
    endfunction

    // Bounded wait for any strobe; on timeout v stays 0 so the caller's check fails.
    task automatic wait_vld(input int limit, output int cycles, output logic [3:0] v);
        cycles = 0;
        v = '0;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            v = freq_vld;
            if (v != 4'b0) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        scan_en = 1'b0;
        chan_en = 4'b0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if ({fo1, fo2, fo3, fo4} !== 80'd0) $display("FAIL reset_freq: got %h expected 0", {fo1, fo2, fo3, fo4});
        else n_pass++;
        n_total++;
        if (freq_vld !== 4'b0 || freq_ovf !== 4'b0)
            $display("FAIL reset_flags: got vld=%b ovf=%b expected 0000/0000", freq_vld, freq_ovf);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || cur_chan !== 2'd0)
            $display("FAIL reset_state: got busy=%b cur=%0d expected 0/0", busy, cur_chan);
        else n_pass++;
    endtask

    task automatic test_single();
        int cyc;
        logic [3:0] v;
        chan_en = 4'b0001;
        scan_en = 1'b1;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy);
        else n_pass++;
        // scan_en sampled at the next edge; strobe visible 2006 edges later.
        wait_vld(2100, cyc, v);
        cyc++;
        n_total++;
        if (cyc !== 2007 || v !== 4'b0001)
            $display("FAIL single_first: got cyc=%0d vld=%b expected 2007/0001", cyc, v);
        else n_pass++;
        n_total++;
        if (fo1 !== 20'd100000 || freq_ovf[0] !== 1'b0)
            $display("FAIL single_value: got %0d ovf=%b expected 100000/0", fo1, freq_ovf[0]);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (freq_vld !== 4'b0) $display("FAIL single_strobe_width: got %b expected 0000", freq_vld);
        else n_pass++;
        wait_vld(2100, cyc, v);
        n_total++;
        if (cyc !== 2005 || v !== 4'b0001)
            $display("FAIL single_repeat: got cyc=%0d vld=%b expected 2005/0001", cyc, v);
        else n_pass++;
    endtask

    task automatic test_four_channels();
        int cyc;
        int ch;
        logic [3:0] v;
        logic [3:0] ev;
        chan_en = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            ch = (k + 1) % 4;
            ev = 4'b0001 << ch;
            wait_vld(2100, cyc, v);
            n_total++;
            if (cyc !== 2006 || v !== ev)
                $display("FAIL four_order[%0d]: got cyc=%0d vld=%b expected 2006/%b", k, cyc, v, ev);
            else n_pass++;
            n_total++;
            if (fout(ch) !== 20'(exp_hz[ch]) || freq_ovf !== 4'b0)
                $display("FAIL four_value[%0d]: got %0d ovf=%b expected %0d/0000",
                         ch, fout(ch), freq_ovf, exp_hz[ch]);
            else n_pass++;
            n_total++;
            if (cur_chan !== 2'(ch)) $display("FAIL four_cur_chan: got %0d expected %0d", cur_chan, ch);
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        int cyc;
        logic [3:0] v;
        per[1] = 2;
        for (int k = 0; k < 4; k++) wait_vld(2100, cyc, v);
        n_total++;
        if (v !== 4'b0010 || fo2 !== 20'hFFFFF || freq_ovf !== 4'b0010)
            $display("FAIL ovf_set: got vld=%b freq=%h ovf=%b expected 0010/fffff/0010", v, fo2, freq_ovf);
        else n_pass++;
        per[1] = 200;
        for (int k = 0; k < 4; k++) wait_vld(2100, cyc, v);
        n_total++;
        if (v !== 4'b0010 || fo2 !== 20'd100000 || freq_ovf !== 4'b0000)
            $display("FAIL ovf_clear: got vld=%b freq=%0d ovf=%b expected 0010/100000/0000", v, fo2, freq_ovf);
        else n_pass++;
    endtask

    task automatic test_abort();
        int cyc;
        logic [3:0] v;
        chan_en = 4'b0101;
        repeat (1000) @(negedge clk);
        n_total++;
        if (cur_chan !== 2'd2) $display("FAIL abort_on_chan2: got %0d expected 2", cur_chan);
        else n_pass++;
        chan_en = 4'b0001;
        @(negedge clk);
        @(negedge clk);
        n_total++;
        if (cur_chan !== 2'd0 || busy !== 1'b1)
            $display("FAIL abort_next: got cur=%0d busy=%b expected 0/1", cur_chan, busy);
        else n_pass++;
        wait_vld(2100, cyc, v);
        cyc += 2;
        n_total++;
        if (cyc !== 2007 || v !== 4'b0001)
            $display("FAIL abort_restart: got cyc=%0d vld=%b expected 2007/0001", cyc, v);
        else n_pass++;
        n_total++;
        if (fo3 !== 20'd20000) $display("FAIL abort_keep: got %0d expected 20000", fo3);
        else n_pass++;
    endtask

    task automatic test_scan_drop();
        int cyc;
        logic [3:0] v;
        chan_en = 4'b0011;
        repeat (1000) @(negedge clk);
        scan_en = 1'b0;
        wait_vld(2100, cyc, v);
        n_total++;
        if (v !== 4'b0010 || fo2 !== 20'd100000 || busy !== 1'b1)
            $display("FAIL drop_store: got vld=%b freq=%0d busy=%b expected 0010/100000/1", v, fo2, busy);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL drop_busy: got %b expected 0", busy);
        else n_pass++;
        wait_vld(2100, cyc, v);
        n_total++;
        if (v !== 4'b0 || busy !== 1'b0) $display("FAIL drop_quiet: got vld=%b busy=%b expected 0000/0", v, busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [3:0] v;
        chan_en = 4'b1111;
        scan_en = 1'b1;
        repeat (1000) @(negedge clk);
        n_total++;
        if (cur_chan !== 2'd2) $display("FAIL rstmid_chan: got %0d expected 2", cur_chan);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({fo1, fo2, fo3, fo4} !== 80'd0 || freq_vld !== 4'b0 || freq_ovf !== 4'b0)
            $display("FAIL rstmid_clear: got freq=%h vld=%b ovf=%b expected 0", {fo1, fo2, fo3, fo4},
                     freq_vld, freq_ovf);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0 || cur_chan !== 2'd0)
            $display("FAIL rstmid_state: got busy=%b cur=%0d expected 0/0", busy, cur_chan);
        else n_pass++;
        rst = 1'b0;
        wait_vld(2100, cyc, v);
        n_total++;
        if (cyc !== 2007 || v !== 4'b0001 || fo1 !== 20'd100000)
            $display("FAIL rstmid_first: got cyc=%0d vld=%b freq=%0d expected 2007/0001/100000", cyc, v, fo1);
        else n_pass++;
    endtask

    initial begin
        per[0] = 200;
        per[1] = 400;
        per[2] = 1000;
        per[3] = 2000;
        exp_hz[0] = 100000;
        exp_hz[1] = 50000;
        exp_hz[2] = 20000;
        exp_hz[3] = 10000;
        rst = 1'b1;
        scan_en = 1'b0;
        chan_en = 4'b0000;
        test_reset();
        test_single();
        per[1] = 200;
        test_four_channels_pre();
        test_overflow();
        test_abort();
        test_scan_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Channel 1 runs at 400 for the four-channel sweep; restored before it is next measured.
    task automatic test_four_channels_pre();
        per[1] = 400;
        test_four_channels();
        per[1] = 200;
    endtask

endmodule
